// File: rtl/irq_source_conditioner.sv
// Interrupt source front end: synchronises raw device lines, applies per-source polarity and
// edge/level trigger mode, and holds edge requests pending until the serving core clears them.
module irq_source_conditioner #(
  parameter int unsigned NUM_SRC     = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ID_W        = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] dev_irq,
  input  logic [NUM_SRC-1:0] polarity,
  input  logic [NUM_SRC-1:0] trig_mode,
  input  logic               clr_valid,
  input  logic [ID_W-1:0]    clr_id,
  input  logic               ovf_clr,
  output logic [NUM_SRC-1:0] irq,
  output logic [NUM_SRC-1:0] pend_ovf
);

  localparam int unsigned WarmW = $clog2(SYNC_STAGES + 2);
  localparam logic [WarmW-1:0] WarmInit = WarmW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
  logic [NUM_SRC-1:0] sync_s;
  logic [NUM_SRC-1:0] active_s;
  logic [NUM_SRC-1:0] active_q;
  logic [NUM_SRC-1:0] edge_s;
  logic [NUM_SRC-1:0] clr_hit;
  logic [NUM_SRC-1:0] irq_d, irq_q;
  logic [NUM_SRC-1:0] ovf_d, ovf_q;
  logic [WarmW-1:0]   warm_d, warm_q;
  logic               warm_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= dev_irq;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_s    = sync_q[SYNC_STAGES-1];
  assign active_s  = sync_s ^ polarity;
  assign warm_done = (warm_q == '0);

  // Inverted lines idle high while the synchroniser still holds reset zeros, so edges seen
  // before the chain has filled are not real and must be dropped.
  assign edge_s = active_s & ~active_q & {NUM_SRC{warm_done}};

  always_comb begin
    warm_d = warm_q;
    if (!warm_done) begin
      warm_d = warm_q - 1'b1;
    end
  end

  // Out-of-range clr_id matches no source, so it falls out of the decode naturally.
  always_comb begin
    clr_hit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      clr_hit[i] = clr_valid && (clr_id == ID_W'(i));
    end
  end

  always_comb begin
    irq_d = '0;
    ovf_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (trig_mode[i]) begin
        irq_d[i] = edge_s[i] | (irq_q[i] & ~clr_hit[i]);
        ovf_d[i] = (ovf_q[i] & ~ovf_clr) | (edge_s[i] & irq_q[i] & ~clr_hit[i]);
      end else begin
        irq_d[i] = active_s[i];
        ovf_d[i] = ovf_q[i] & ~ovf_clr;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= '0;
      irq_q    <= '0;
      ovf_q    <= '0;
      warm_q   <= WarmInit;
    end else begin
      active_q <= active_s;
      irq_q    <= irq_d;
      ovf_q    <= ovf_d;
      warm_q   <= warm_d;
    end
  end

  assign irq      = irq_q;
  assign pend_ovf = ovf_q;

endmodule

// File: tb/tb_irq_source_conditioner.sv
// Directed bench for irq_source_conditioner: a 32-source instance plus a 16-source build
// used to check clears addressed beyond the source count.
module tb_irq_source_conditioner;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dev_irq, polarity, trig_mode;
  logic        clr_valid, ovf_clr;
  logic [4:0]  clr_id;
  logic [31:0] irq, pend_ovf;

  logic [15:0] dev16, pol16, trig16, irq16, ovf16;
  logic        clr_valid16, ovf_clr16;
  logic [4:0]  clr_id16;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  irq_source_conditioner #(.NUM_SRC(32), .SYNC_STAGES(2), .ID_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .dev_irq   (dev_irq),
    .polarity  (polarity),
    .trig_mode (trig_mode),
    .clr_valid (clr_valid),
    .clr_id    (clr_id),
    .ovf_clr   (ovf_clr),
    .irq       (irq),
    .pend_ovf  (pend_ovf)
  );

  irq_source_conditioner #(.NUM_SRC(16), .SYNC_STAGES(2), .ID_W(5)) dut16 (
    .clk       (clk),
    .reset     (reset),
    .dev_irq   (dev16),
    .polarity  (pol16),
    .trig_mode (trig16),
    .clr_valid (clr_valid16),
    .clr_id    (clr_id16),
    .ovf_clr   (ovf_clr16),
    .irq       (irq16),
    .pend_ovf  (ovf16)
  );

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clr(input logic [4:0] id);
    clr_valid = 1'b1;
    clr_id    = id;
    tick(1);
    clr_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    total++;
    if (irq !== 32'h0) begin
      bad++; $display("FAIL reset_irq actual=%h required=%h", irq, 32'h0);
    end
    total++;
    if (pend_ovf !== 32'h0) begin
      bad++; $display("FAIL reset_ovf actual=%h required=%h", pend_ovf, 32'h0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    // Active-low bit 14 idles high through reset: no request during or after warm-up.
    for (int c = 0; c < 6; c++) begin
      tick(1);
      total++;
      if (irq !== 32'h0) begin
        bad++; $display("FAIL warmup_irq cycle=%0d actual=%h required=%h", c, irq, 32'h0);
      end
    end
  endtask

  task automatic test_active_low;
    dev_irq[14] = 1'b0;
    tick(2);
    total++;
    if (irq[14] !== 1'b0) begin
      bad++; $display("FAIL actlow_early actual=%b required=0", irq[14]);
    end
    tick(1);
    total++;
    if (irq[14] !== 1'b1) begin
      bad++; $display("FAIL actlow_set actual=%b required=1", irq[14]);
    end
    dev_irq[14] = 1'b1;
    pulse_clr(5'd14);
    total++;
    if (irq[14] !== 1'b0) begin
      bad++; $display("FAIL actlow_clr actual=%b required=0", irq[14]);
    end
  endtask

  task automatic test_edge31;
    dev_irq[31] = 1'b1;
    tick(2);
    total++;
    if (irq[31] !== 1'b0) begin
      bad++; $display("FAIL edge31_early actual=%b required=0", irq[31]);
    end
    tick(1);
    total++;
    if (irq[31] !== 1'b1) begin
      bad++; $display("FAIL edge31_set actual=%b required=1", irq[31]);
    end
    dev_irq[31] = 1'b0;
    tick(4);
    total++;
    if (irq !== 32'h8000_0000) begin
      bad++; $display("FAIL edge31_hold actual=%h required=%h", irq, 32'h8000_0000);
    end
    pulse_clr(5'd31);
    total++;
    if (irq[31] !== 1'b0) begin
      bad++; $display("FAIL edge31_clr actual=%b required=0", irq[31]);
    end
  endtask

  task automatic test_level6;
    dev_irq[6] = 1'b1;
    tick(2);
    total++;
    if (irq[6] !== 1'b0) begin
      bad++; $display("FAIL level6_early actual=%b required=0", irq[6]);
    end
    tick(1);
    total++;
    if (irq[6] !== 1'b1) begin
      bad++; $display("FAIL level6_set actual=%b required=1", irq[6]);
    end
    pulse_clr(5'd6);
    total++;
    if (irq[6] !== 1'b1) begin
      bad++; $display("FAIL level6_clr_ignored actual=%b required=1", irq[6]);
    end
    dev_irq[6] = 1'b0;
    tick(2);
    total++;
    if (irq[6] !== 1'b1) begin
      bad++; $display("FAIL level6_deassert_early actual=%b required=1", irq[6]);
    end
    tick(1);
    total++;
    if (irq[6] !== 1'b0) begin
      bad++; $display("FAIL level6_deassert actual=%b required=0", irq[6]);
    end
    total++;
    if (pend_ovf !== 32'h0) begin
      bad++; $display("FAIL level6_ovf actual=%h required=%h", pend_ovf, 32'h0);
    end
  endtask

  task automatic test_back_to_back;
    dev_irq[0] = 1'b1;
    tick(3);
    dev_irq[0] = 1'b0;
    tick(3);
    // Second rising edge: it reaches the sync output two edges later, same cycle as the clear.
    dev_irq[0] = 1'b1;
    tick(2);
    clr_valid = 1'b1;
    clr_id    = 5'd0;
    tick(1);
    clr_valid = 1'b0;
    total++;
    if (irq[0] !== 1'b1) begin
      bad++; $display("FAIL b2b_set_wins actual=%b required=1", irq[0]);
    end
    total++;
    if (pend_ovf[0] !== 1'b0) begin
      bad++; $display("FAIL b2b_no_ovf actual=%b required=0", pend_ovf[0]);
    end
    dev_irq[0] = 1'b0;
    tick(3);
    dev_irq[0] = 1'b1;
    tick(3);
    total++;
    if (pend_ovf !== 32'h1) begin
      bad++; $display("FAIL b2b_ovf_set actual=%h required=%h", pend_ovf, 32'h1);
    end
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    total++;
    if (pend_ovf[0] !== 1'b0) begin
      bad++; $display("FAIL b2b_ovf_clr actual=%b required=0", pend_ovf[0]);
    end
    dev_irq[0] = 1'b0;
    pulse_clr(5'd0);
    total++;
    if (irq !== 32'h0) begin
      bad++; $display("FAIL b2b_final_clr actual=%h required=%h", irq, 32'h0);
    end
  endtask

  task automatic test_out_of_range;
    trig_mode[6] = 1'b1;
    tick(4);
    // Bit 14 is active-low: driving it low raises its request alongside the others.
    dev_irq = 32'h0000_26CF;
    tick(3);
    total++;
    if (irq !== 32'h0000_66CF) begin
      bad++; $display("FAIL oor_pending actual=%h required=%h", irq, 32'h0000_66CF);
    end
    pulse_clr(5'd31);
    tick(1);
    total++;
    if (irq !== 32'h0000_66CF) begin
      bad++; $display("FAIL oor_idle31 actual=%h required=%h", irq, 32'h0000_66CF);
    end
    dev16[3] = 1'b1;
    tick(3);
    total++;
    if (irq16 !== 16'h0008) begin
      bad++; $display("FAIL n16_set actual=%h required=%h", irq16, 16'h0008);
    end
    clr_valid16 = 1'b1;
    clr_id16    = 5'd20;
    tick(1);
    clr_valid16 = 1'b0;
    total++;
    if (irq16 !== 16'h0008) begin
      bad++; $display("FAIL n16_clr20 actual=%h required=%h", irq16, 16'h0008);
    end
    clr_valid16 = 1'b1;
    clr_id16    = 5'd3;
    tick(1);
    clr_valid16 = 1'b0;
    total++;
    if (irq16 !== 16'h0000) begin
      bad++; $display("FAIL n16_clr3 actual=%h required=%h", irq16, 16'h0000);
    end
  endtask

  task automatic test_reset_midop;
    dev_irq[3] = 1'b0;
    tick(3);
    dev_irq[3] = 1'b1;
    tick(3);
    total++;
    if (pend_ovf !== 32'h0000_0008) begin
      bad++; $display("FAIL midop_ovf3 actual=%h required=%h", pend_ovf, 32'h0000_0008);
    end
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    total++;
    if (irq !== 32'h0) begin
      bad++; $display("FAIL midop_irq actual=%h required=%h", irq, 32'h0);
    end
    total++;
    if (pend_ovf !== 32'h0) begin
      bad++; $display("FAIL midop_ovf actual=%h required=%h", pend_ovf, 32'h0);
    end
    dev_irq = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    reset = 1'b0;
    // Lines rise while warm-up is still running, so those edges are never captured.
    for (int c = 0; c < 4; c++) begin
      tick(1);
      total++;
      if (irq !== 32'h0) begin
        bad++; $display("FAIL post_reset_irq cycle=%0d actual=%h required=%h", c, irq, 32'h0);
      end
    end
    trig_mode[6] = 1'b0;
    tick(1);
    total++;
    if (irq !== 32'h0000_0040) begin
      bad++; $display("FAIL edge_to_level actual=%h required=%h", irq, 32'h0000_0040);
    end
  endtask

  initial begin
    reset       = 1'b1;
    dev_irq     = 32'h0000_4000;
    polarity    = 32'h0000_4000;
    trig_mode   = ~32'h0000_0040;
    clr_valid   = 1'b0;
    clr_id      = '0;
    ovf_clr     = 1'b0;
    dev16       = '0;
    pol16       = '0;
    trig16      = '1;
    clr_valid16 = 1'b0;
    clr_id16    = '0;
    ovf_clr16   = 1'b0;
    test_reset();
    test_active_low();
    test_edge31();
    test_level6();
    test_back_to_back();
    test_out_of_range();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
